// File: rtl/univ_register.sv
// Universal register: load, shift, rotate, increment/decrement, with carry/borrow and zero flags.
// Optional shadow register (save/restore/swap) compiled in by defining UNIV_REGISTER_SHADOW_EN.
module univ_register #(
  parameter int unsigned         WIDTH     = 8,
  parameter logic [WIDTH-1:0]    RESET_VAL = '0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic [2:0]       op_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             ser_i,
  input  logic             save_i,
  input  logic             restore_i,
  output logic [WIDTH-1:0] out_o,
  output logic             carry_o,
  output logic             zero_o,
  output logic [WIDTH-1:0] shadow_o
);

  localparam logic [2:0] OP_HOLD = 3'b000;
  localparam logic [2:0] OP_LOAD = 3'b001;
  localparam logic [2:0] OP_SHL  = 3'b010;
  localparam logic [2:0] OP_SHR  = 3'b011;
  localparam logic [2:0] OP_ROL  = 3'b100;
  localparam logic [2:0] OP_ROR  = 3'b101;
  localparam logic [2:0] OP_INC  = 3'b110;
  localparam logic [2:0] OP_DEC  = 3'b111;

  logic [WIDTH-1:0] out_q, out_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] op_res;
  logic             op_carry;

  // Result of the selected operation on the current main register value
  always_comb begin
    op_res   = out_q;
    op_carry = carry_q;
    unique case (op_i)
      OP_HOLD: begin
        op_res   = out_q;
        op_carry = carry_q;
      end
      OP_LOAD: begin
        op_res   = data_i;
        op_carry = 1'b0;
      end
      OP_SHL: begin
        op_res   = {out_q[WIDTH-2:0], ser_i};
        op_carry = out_q[WIDTH-1];
      end
      OP_SHR: begin
        op_res   = {ser_i, out_q[WIDTH-1:1]};
        op_carry = out_q[0];
      end
      OP_ROL: begin
        op_res   = {out_q[WIDTH-2:0], out_q[WIDTH-1]};
        op_carry = out_q[WIDTH-1];
      end
      OP_ROR: begin
        op_res   = {out_q[0], out_q[WIDTH-1:1]};
        op_carry = out_q[0];
      end
      OP_INC: begin
        op_res   = out_q + WIDTH'(1);
        op_carry = &out_q;
      end
      OP_DEC: begin
        op_res   = out_q - WIDTH'(1);
        op_carry = ~|out_q;
      end
      default: begin
        op_res   = out_q;
        op_carry = carry_q;
      end
    endcase
  end

`ifdef UNIV_REGISTER_SHADOW_EN
  logic [WIDTH-1:0] shadow_q, shadow_d;

  // Priority clr > restore > op; save copies the pre-edge value, so save+restore swaps
  always_comb begin
    out_d    = op_res;
    carry_d  = op_carry;
    shadow_d = shadow_q;
    if (save_i) begin
      shadow_d = out_q;
    end
    if (clr_i) begin
      out_d   = '0;
      carry_d = 1'b0;
    end else if (restore_i) begin
      out_d   = shadow_q;
      carry_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      shadow_q <= '0;
    end else begin
      shadow_q <= shadow_d;
    end
  end

  assign shadow_o = shadow_q;
`else
  logic unused_shadow_ctrl;

  always_comb begin
    out_d   = op_res;
    carry_d = op_carry;
    if (clr_i) begin
      out_d   = '0;
      carry_d = 1'b0;
    end
  end

  assign unused_shadow_ctrl = save_i ^ restore_i;
  assign shadow_o           = '0;
`endif

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      out_q   <= RESET_VAL;
      carry_q <= 1'b0;
    end else begin
      out_q   <= out_d;
      carry_q <= carry_d;
    end
  end

  assign out_o   = out_q;
  assign carry_o = carry_q;
  assign zero_o  = (out_q == '0);

endmodule

// File: tb/tb_univ_register.sv
// Directed self-checking bench for univ_register: an 8-bit instance and a 16-bit instance
// with a non-zero reset value; shadow expectations follow UNIV_REGISTER_SHADOW_EN.
module tb_univ_register;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        clr_i;
  logic [2:0]  op_i;
  logic [7:0]  data_i;
  logic        ser_i;
  logic        save_i;
  logic        restore_i;
  logic [7:0]  out_o;
  logic        carry_o;
  logic        zero_o;
  logic [7:0]  shadow_o;

  logic        b_rst_ni;
  logic        b_clr_i;
  logic [2:0]  b_op_i;
  logic [15:0] b_data_i;
  logic        b_ser_i;
  logic        b_save_i;
  logic        b_restore_i;
  logic [15:0] b_out_o;
  logic        b_carry_o;
  logic        b_zero_o;
  logic [15:0] b_shadow_o;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  always #5 clk_i = ~clk_i;

  univ_register #(.WIDTH(8), .RESET_VAL(8'h00)) u_dut8 (
    .clk_i(clk_i), .rst_ni(rst_ni), .clr_i(clr_i), .op_i(op_i), .data_i(data_i),
    .ser_i(ser_i), .save_i(save_i), .restore_i(restore_i), .out_o(out_o),
    .carry_o(carry_o), .zero_o(zero_o), .shadow_o(shadow_o)
  );

  univ_register #(.WIDTH(16), .RESET_VAL(16'h8000)) u_dut16 (
    .clk_i(clk_i), .rst_ni(b_rst_ni), .clr_i(b_clr_i), .op_i(b_op_i), .data_i(b_data_i),
    .ser_i(b_ser_i), .save_i(b_save_i), .restore_i(b_restore_i), .out_o(b_out_o),
    .carry_o(b_carry_o), .zero_o(b_zero_o), .shadow_o(b_shadow_o)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are checked at the same point
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drv(input logic [2:0] op, input logic [7:0] d, input logic ser,
                     input logic sv, input logic rs, input logic cl);
    op_i = op; data_i = d; ser_i = ser; save_i = sv; restore_i = rs; clr_i = cl;
  endtask

  initial begin
    rst_ni = 1'b0;
    drv(3'b110, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
    b_rst_ni = 1'b0; b_clr_i = 1'b0; b_op_i = 3'b000; b_data_i = 16'h0;
    b_ser_i = 1'b0; b_save_i = 1'b0; b_restore_i = 1'b0;
    tick();
    tick();
    chk("rst_out", 64'(out_o), 64'h00);
    chk("rst_carry", 64'(carry_o), 64'h0);
    chk("rst_zero", 64'(zero_o), 64'h1);
    chk("rst_shadow", 64'(shadow_o), 64'h00);
    chk("b_rst_out", 64'(b_out_o), 64'h8000);

    rst_ni = 1'b1;
    drv(3'b001, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b0); tick();
    chk("load_a5", 64'(out_o), 64'hA5);
    chk("load_carry", 64'(carry_o), 64'h0);
    drv(3'b100, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0); tick();
    chk("rol_out", 64'(out_o), 64'h4B);
    chk("rol_carry", 64'(carry_o), 64'h1);
    drv(3'b101, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0); tick();
    chk("ror_out", 64'(out_o), 64'hA5);
    chk("ror_carry", 64'(carry_o), 64'h1);
    drv(3'b000, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0); tick();
    chk("hold_out", 64'(out_o), 64'hA5);
    chk("hold_carry", 64'(carry_o), 64'h1);

    drv(3'b001, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0); tick();
    chk("load_ff_carry", 64'(carry_o), 64'h0);
    drv(3'b110, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0); tick();
    chk("inc_wrap_out", 64'(out_o), 64'h00);
    chk("inc_wrap_carry", 64'(carry_o), 64'h1);
    chk("inc_wrap_zero", 64'(zero_o), 64'h1);
    drv(3'b111, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0); tick();
    chk("dec_wrap_out", 64'(out_o), 64'hFF);
    chk("dec_wrap_carry", 64'(carry_o), 64'h1);
    chk("dec_wrap_zero", 64'(zero_o), 64'h0);
    drv(3'b111, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0); tick();
    chk("dec_out", 64'(out_o), 64'hFE);
    chk("dec_carry", 64'(carry_o), 64'h0);

    drv(3'b001, 8'h81, 1'b0, 1'b0, 1'b0, 1'b0); tick();
    drv(3'b010, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0); tick();
    chk("shl_out", 64'(out_o), 64'h02);
    chk("shl_carry", 64'(carry_o), 64'h1);
    drv(3'b011, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0); tick();
    chk("shr_out", 64'(out_o), 64'h81);
    chk("shr_carry", 64'(carry_o), 64'h0);

`ifdef UNIV_REGISTER_SHADOW_EN
    drv(3'b001, 8'h3C, 1'b0, 1'b0, 1'b0, 1'b0); tick();
    drv(3'b000, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0); tick();
    chk("save_shadow", 64'(shadow_o), 64'h3C);
    drv(3'b001, 8'h11, 1'b0, 1'b0, 1'b0, 1'b0); tick();
    drv(3'b110, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0); tick();
    chk("swap_out", 64'(out_o), 64'h3C);
    chk("swap_shadow", 64'(shadow_o), 64'h11);
    chk("swap_carry", 64'(carry_o), 64'h0);
    drv(3'b001, 8'h99, 1'b0, 1'b0, 1'b1, 1'b0); tick();
    chk("restore_out", 64'(out_o), 64'h11);
    // Reset between save and restore discards the saved value
    drv(3'b001, 8'h77, 1'b0, 1'b0, 1'b0, 1'b0); tick();
    drv(3'b000, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0); tick();
    chk("save2_shadow", 64'(shadow_o), 64'h77);
    rst_ni = 1'b0; tick();
    chk("midrst_shadow", 64'(shadow_o), 64'h00);
    rst_ni = 1'b1;
    drv(3'b001, 8'h12, 1'b0, 1'b0, 1'b0, 1'b0); tick();
    drv(3'b000, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0); tick();
    chk("restore_after_rst", 64'(out_o), 64'h00);
`else
    drv(3'b001, 8'h3C, 1'b0, 1'b1, 1'b0, 1'b0); tick();
    chk("nosh_save_shadow", 64'(shadow_o), 64'h00);
    chk("nosh_load_out", 64'(out_o), 64'h3C);
    drv(3'b001, 8'h22, 1'b0, 1'b1, 1'b1, 1'b0); tick();
    chk("nosh_restore_ignored", 64'(out_o), 64'h22);
    chk("nosh_shadow", 64'(shadow_o), 64'h00);
`endif

    drv(3'b001, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0); tick();
    drv(3'b111, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0); tick();
    chk("pre_clr_carry", 64'(carry_o), 64'h1);
    drv(3'b001, 8'h55, 1'b0, 1'b0, 1'b1, 1'b1); tick();
    chk("clr_out", 64'(out_o), 64'h00);
    chk("clr_carry", 64'(carry_o), 64'h0);
    chk("clr_zero", 64'(zero_o), 64'h1);
    drv(3'b001, 8'h5A, 1'b0, 1'b0, 1'b0, 1'b0); tick();
    rst_ni = 1'b0;
    drv(3'b110, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0); tick();
    chk("rst_inc_out", 64'(out_o), 64'h00);
    chk("rst_inc_shadow", 64'(shadow_o), 64'h00);
    rst_ni = 1'b1;
    drv(3'b000, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);

    b_rst_ni = 1'b1;
    b_op_i = 3'b111; tick();
    chk("b_dec_out", 64'(b_out_o), 64'h7FFF);
    chk("b_dec_carry", 64'(b_carry_o), 64'h0);
    b_op_i = 3'b000; b_save_i = 1'b1; tick();
    b_save_i = 1'b0;
`ifdef UNIV_REGISTER_SHADOW_EN
    chk("b_save_shadow", 64'(b_shadow_o), 64'h7FFF);
`else
    chk("b_save_shadow", 64'(b_shadow_o), 64'h0000);
`endif
    b_op_i = 3'b110; tick();
    chk("b_inc_out", 64'(b_out_o), 64'h8000);
    chk("b_inc_carry", 64'(b_carry_o), 64'h0);
    b_op_i = 3'b100; tick();
    chk("b_rol_out", 64'(b_out_o), 64'h0001);
    chk("b_rol_carry", 64'(b_carry_o), 64'h1);
    b_op_i = 3'b000;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
